// File: rtl/lsu_mem_ctrl.sv
// Purpose: single-outstanding load/store sequencer in front of memory_bus (range check, strobe build, load extension).
// Latency: bus strobe 1 cycle after accept; result 1 cycle after the bus response, or TIMEOUT cycles after entering WAIT.
// Backpressure: lsu_req_ready only while idle; the result is held stable until lsu_rsp_ready.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   flush                          squashes the pending op or its held result
//   lsu_req_* / lsu_addr.. lsu_tag request from execute (valid/ready)
//   lsu_rsp_*                      result to writeback (valid/ready), err 0=ok 1=access fault 2=timeout
//   mem_mstReq_valid, mem_*        one-cycle request strobe and payload to memory_bus
//   mem_data_r, mem_slvRsp_valid   response from memory_bus
module lsu_mem_ctrl #(
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             lsu_req_valid,
  output logic             lsu_req_ready,
  input  logic [63:0]      lsu_addr,
  input  logic [63:0]      lsu_data_w,
  input  logic [1:0]       lsu_size,
  input  logic             lsu_unsigned,
  input  logic             lsu_wen,
  input  logic [TAG_W-1:0] lsu_tag,
  output logic             lsu_rsp_valid,
  input  logic             lsu_rsp_ready,
  output logic [63:0]      lsu_rsp_data,
  output logic [TAG_W-1:0] lsu_rsp_tag,
  output logic [1:0]       lsu_rsp_err,
  output logic             mem_mstReq_valid,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_data_w,
  output logic [7:0]       mem_wstrb,
  output logic             mem_wen,
  input  logic [63:0]      mem_data_r,
  input  logic             mem_slvRsp_valid
);

  localparam int               CNT_W       = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       ERR_OK      = 2'd0;
  localparam logic [1:0]       ERR_ACCESS  = 2'd1;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  // Two 256 MiB windows are mapped: 0x8000_0000.. and 0x9000_0000..
  function automatic logic addr_legal(input logic [63:0] addr);
    logic [63:0] hi;
    hi = addr | 64'h0000_0000_0FFF_FFFF;
    return (hi == 64'h0000_0000_8FFF_FFFF) || (hi == 64'h0000_0000_9FFF_FFFF);
  endfunction

  // Unshifted byte mask; memory_bus applies the address offset itself.
  function automatic logic [7:0] size_strb(input logic wen, input logic [1:0] size);
    logic [7:0] strb;
    strb = 8'h00;
    if (wen) begin
      case (size)
        2'd0:    strb = 8'h01;
        2'd1:    strb = 8'h03;
        2'd2:    strb = 8'h0F;
        default: strb = 8'hFF;
      endcase
    end
    return strb;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic zext);
    logic [63:0] res;
    res = raw;
    case (size)
      2'd0:    res = zext ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    res = zext ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    res = zext ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  state_t           state_q, state_d;

  // Captured request fields
  logic             wen_q, wen_d;
  logic [1:0]       size_q, size_d;
  logic             zext_q, zext_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             legal_q, legal_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Registered outputs
  logic             req_rdy_q, req_rdy_d;
  logic             mreq_vld_q, mreq_vld_d;
  logic [63:0]      maddr_q, maddr_d;
  logic [63:0]      mdat_q, mdat_d;
  logic [7:0]       mwstrb_q, mwstrb_d;
  logic             mwen_q, mwen_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [63:0]      rsp_dat_q, rsp_dat_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [1:0]       rsp_err_q, rsp_err_d;

  logic             accept;
  logic             drop_now;
  logic             tmo_hit;

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    zext_d     = zext_q;
    tag_d      = tag_q;
    legal_d    = legal_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    mreq_vld_d = mreq_vld_q;
    maddr_d    = maddr_q;
    mdat_d     = mdat_q;
    mwstrb_d   = mwstrb_q;
    mwen_d     = mwen_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    accept     = 1'b0;
    drop_now   = 1'b0;
    tmo_hit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        accept = lsu_req_valid & req_rdy_q & ~flush;
        if (accept) begin
          state_d = ST_REQ;
          wen_d   = lsu_wen;
          size_d  = lsu_size;
          zext_d  = lsu_unsigned;
          tag_d   = lsu_tag;
          legal_d = addr_legal(lsu_addr);
          // The strobe and payload are loaded here so they appear exactly during REQ.
          if (legal_d) begin
            mreq_vld_d = 1'b1;
            maddr_d    = lsu_addr;
            mdat_d     = lsu_data_w;
            mwstrb_d   = size_strb(lsu_wen, lsu_size);
            mwen_d     = lsu_wen;
          end
        end
      end

      ST_REQ: begin
        mreq_vld_d = 1'b0;
        maddr_d    = '0;
        mdat_d     = '0;
        mwstrb_d   = '0;
        mwen_d     = 1'b0;
        // A flush here cannot retract the strobe already on the bus; it only marks the result dead.
        drop_now   = drop_q | flush;
        if (legal_q) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          drop_d  = drop_now;
        end else if (drop_now) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end else begin
          state_d   = ST_RESP;
          rsp_vld_d = 1'b1;
          rsp_dat_d = '0;
          rsp_tag_d = tag_q;
          rsp_err_d = ERR_ACCESS;
        end
      end

      ST_WAIT: begin
        drop_now = drop_q | flush;
        drop_d   = drop_now;
        cnt_d    = cnt_q + 1'b1;
        tmo_hit  = (cnt_q == CNT_LAST);
        // A response in the timeout cycle still counts as a normal completion.
        if (mem_slvRsp_valid || tmo_hit) begin
          if (drop_now) begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d   = ST_RESP;
            rsp_vld_d = 1'b1;
            rsp_tag_d = tag_q;
            if (mem_slvRsp_valid) begin
              rsp_err_d = ERR_OK;
              rsp_dat_d = wen_q ? 64'd0 : load_extend(mem_data_r, size_q, zext_q);
            end else begin
              rsp_err_d = ERR_TIMEOUT;
              rsp_dat_d = '0;
            end
          end
        end
      end

      ST_RESP: begin
        if (lsu_rsp_ready || flush) begin
          state_d   = ST_IDLE;
          rsp_vld_d = 1'b0;
          rsp_dat_d = '0;
          rsp_tag_d = '0;
          rsp_err_d = ERR_OK;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      zext_q     <= 1'b0;
      tag_q      <= '0;
      legal_q    <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b1;
      mreq_vld_q <= 1'b0;
      maddr_q    <= '0;
      mdat_q     <= '0;
      mwstrb_q   <= '0;
      mwen_q     <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      tag_q      <= tag_d;
      legal_q    <= legal_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      req_rdy_q  <= req_rdy_d;
      mreq_vld_q <= mreq_vld_d;
      maddr_q    <= maddr_d;
      mdat_q     <= mdat_d;
      mwstrb_q   <= mwstrb_d;
      mwen_q     <= mwen_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign lsu_req_ready    = req_rdy_q;
  assign mem_mstReq_valid = mreq_vld_q;
  assign mem_addr         = maddr_q;
  assign mem_data_w       = mdat_q;
  assign mem_wstrb        = mwstrb_q;
  assign mem_wen          = mwen_q;
  assign lsu_rsp_valid    = rsp_vld_q;
  assign lsu_rsp_data     = rsp_dat_q;
  assign lsu_rsp_tag      = rsp_tag_q;
  assign lsu_rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Purpose: randomized + directed bench for lsu_mem_ctrl against a cycle-timeline reference model.
// Latency: expectations are planned per cycle from the transaction timing rules before the run starts.
// Backpressure: writeback ready delays, flushes and resets are scheduled per transaction.
module tb_lsu_mem_ctrl;
  localparam int TAG_W   = 6;
  localparam int TIMEOUT = 16;
  localparam int NCYC    = 6000;

  localparam int S_RDY = 0, S_MVLD = 1, S_WSTRB = 2, S_MWEN = 3, S_MDAT = 4,
                 S_RVLD = 5, S_RDAT = 6, S_RERR = 7, S_MADDR = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             flush = 1'b0;
  logic             lsu_req_valid = 1'b0;
  logic             lsu_req_ready;
  logic [63:0]      lsu_addr = '0;
  logic [63:0]      lsu_data_w = '0;
  logic [1:0]       lsu_size = '0;
  logic             lsu_unsigned = 1'b0;
  logic             lsu_wen = 1'b0;
  logic [TAG_W-1:0] lsu_tag = '0;
  logic             lsu_rsp_valid;
  logic             lsu_rsp_ready = 1'b0;
  logic [63:0]      lsu_rsp_data;
  logic [TAG_W-1:0] lsu_rsp_tag;
  logic [1:0]       lsu_rsp_err;
  logic             mem_mstReq_valid;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_data_w;
  logic [7:0]       mem_wstrb;
  logic             mem_wen;
  logic [63:0]      mem_data_r = '0;
  logic             mem_slvRsp_valid = 1'b0;

  always #5 CLK = ~CLK;

  lsu_mem_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_data_w(lsu_data_w), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_wen(lsu_wen), .lsu_tag(lsu_tag),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_tag(lsu_rsp_tag), .lsu_rsp_err(lsu_rsp_err),
    .mem_mstReq_valid(mem_mstReq_valid), .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_wstrb(mem_wstrb), .mem_wen(mem_wen), .mem_data_r(mem_data_r),
    .mem_slvRsp_valid(mem_slvRsp_valid)
  );

  typedef struct packed {
    logic             rst;
    logic             flush;
    logic             vld;
    logic [63:0]      addr;
    logic [63:0]      wdat;
    logic [1:0]       size;
    logic             uns;
    logic             wen;
    logic [TAG_W-1:0] tag;
    logic             rrdy;
    logic             srsp;
    logic [63:0]      rdat;
  } stim_t;

  typedef struct packed {
    logic             rdy;
    logic             mvld;
    logic [63:0]      maddr;
    logic [63:0]      mdat;
    logic [7:0]       wstrb;
    logic             mwen;
    logic             rvld;
    logic [63:0]      rdat;
    logic [TAG_W-1:0] rtag;
    logic [1:0]       rerr;
  } obs_t;

  typedef struct {
    int          cyc;
    int          sig;
    logic [63:0] val;
  } pin_t;

  stim_t stim [NCYC];
  obs_t  expv [NCYC];
  pin_t  pins [$];

  int tests_run = 0;
  int fails     = 0;

  // ---------------- reference model (transaction level) ----------------
  function automatic bit is_legal(input logic [63:0] a);
    return ((a >> 28) == 64'd8) || ((a >> 28) == 64'd9);
  endfunction

  function automatic logic [63:0] field_mask(input logic [1:0] sz);
    if (sz == 2'd3) return {64{1'b1}};
    return (64'd1 << (8 << sz)) - 64'd1;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [1:0] sz,
                                             input logic uns);
    logic [63:0] m;
    logic [63:0] v;
    int          top;
    m   = field_mask(sz);
    v   = raw & m;
    top = (8 << sz) - 1;
    if (!uns && v[top]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic wen, input logic [1:0] sz);
    int n;
    n = 1 << sz;
    return wen ? 8'((1 << n) - 1) : 8'h00;
  endfunction

  // kind: 0 none, 1 flush in REQ, 2 flush in WAIT (+off), 3 flush in RESP (+off), 4 reset in RESP (+off)
  // d: response delay after WAIT entry; d >= TIMEOUT means the bus never answers.
  task automatic plan_op(input int a, input logic [63:0] addr, input logic [63:0] wdat,
                         input logic [1:0] sz, input logic uns, input logic wen,
                         input logic [TAG_W-1:0] tag, input int d, input logic [63:0] rdat,
                         input int kind_in, input int off, input int r, output int nxt);
    bit          legal;
    int          kind, w, s, e, off2;
    logic [1:0]  err;
    logic [63:0] rd;
    legal = is_legal(addr);
    kind  = kind_in;
    if (!legal && kind == 2) kind = 0;
    stim[a].vld   = 1'b1;
    stim[a].flush = 1'b0;
    stim[a].addr  = addr;
    stim[a].wdat  = wdat;
    stim[a].size  = sz;
    stim[a].uns   = uns;
    stim[a].wen   = wen;
    stim[a].tag   = tag;
    expv[a+1].rdy = 1'b0;
    if (legal) begin
      expv[a+1].mvld  = 1'b1;
      expv[a+1].maddr = addr;
      expv[a+1].mdat  = wdat;
      expv[a+1].wstrb = model_strb(wen, sz);
      expv[a+1].mwen  = wen;
    end
    if (kind == 1) stim[a+1].flush = 1'b1;
    if (legal) begin
      w = a + 2 + ((d < TIMEOUT) ? d : TIMEOUT - 1);
      for (int c = a + 2; c <= w; c++) expv[c].rdy = 1'b0;
      if (d < TIMEOUT) begin
        stim[a+2+d].srsp = 1'b1;
        stim[a+2+d].rdat = rdat;
      end
      if (kind == 2) begin
        off2 = off % (w - a - 1);
        stim[a+2+off2].flush = 1'b1;
      end
      err = (d < TIMEOUT) ? 2'd0 : 2'd2;
      rd  = (d < TIMEOUT && !wen) ? model_load(rdat, sz, uns) : 64'd0;
    end else begin
      w   = a + 1;
      err = 2'd1;
      rd  = 64'd0;
    end
    if (kind == 1 || kind == 2) begin
      nxt = w + 1;
      return;
    end
    s = w + 1;
    e = (kind == 3 || kind == 4) ? s + off : s + r;
    for (int c = s; c <= e; c++) begin
      expv[c].rdy  = 1'b0;
      expv[c].rvld = 1'b1;
      expv[c].rdat = rd;
      expv[c].rtag = tag;
      expv[c].rerr = err;
      stim[c].rrdy = 1'b0;
    end
    if (kind == 3)      stim[e].flush = 1'b1;
    else if (kind == 4) stim[e].rst   = 1'b1;
    else                stim[e].rrdy  = 1'b1;
    nxt = e + 1;
    if (kind == 4) stim[nxt].srsp = 1'b1;  // late bus answer after reset
  endtask

  task automatic pin(input int cyc, input int sig, input logic [63:0] val);
    pin_t p;
    p.cyc = cyc;
    p.sig = sig;
    p.val = val;
    pins.push_back(p);
  endtask

  function automatic logic [63:0] sig_val(input obs_t o, input int sig);
    case (sig)
      S_RDY:   return 64'(o.rdy);
      S_MVLD:  return 64'(o.mvld);
      S_WSTRB: return 64'(o.wstrb);
      S_MWEN:  return 64'(o.mwen);
      S_MDAT:  return o.mdat;
      S_RVLD:  return 64'(o.rvld);
      S_RDAT:  return o.rdat;
      S_RERR:  return 64'(o.rerr);
      default: return o.maddr;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_RDY:   return "lsu_req_ready";
      S_MVLD:  return "mem_mstReq_valid";
      S_WSTRB: return "mem_wstrb";
      S_MWEN:  return "mem_wen";
      S_MDAT:  return "mem_data_w";
      S_RVLD:  return "lsu_rsp_valid";
      S_RDAT:  return "lsu_rsp_data";
      S_RERR:  return "lsu_rsp_err";
      default: return "mem_addr";
    endcase
  endfunction

  initial begin
    int t, a, nxt, gap, sel, d, k, kind, off, r;
    logic [63:0] addr;
    obs_t obs;

    for (int c = 0; c < NCYC; c++) begin
      stim[c]       = '0;
      stim[c].addr  = {$urandom, $urandom};
      stim[c].wdat  = {$urandom, $urandom};
      stim[c].rdat  = {$urandom, $urandom};
      stim[c].size  = 2'($urandom);
      stim[c].uns   = 1'($urandom);
      stim[c].wen   = 1'($urandom);
      stim[c].tag   = TAG_W'($urandom);
      stim[c].rrdy  = 1'($urandom);
      expv[c]       = '0;
      expv[c].rdy   = 1'b1;
    end
    for (int c = 0; c < 3; c++) stim[c].rst = 1'b1;
    pin(1, S_RDY, 64'd1);
    pin(1, S_RVLD, 64'd0);

    // Directed: signed word load
    t = 4; a = t;
    plan_op(a, 64'h8000_0004, 64'h0, 2'd2, 1'b0, 1'b0, 6'd5, 0, 64'h0000_0000_8000_0001, 0, 0, 0, nxt);
    pin(a+1, S_MVLD, 64'd1); pin(a+1, S_WSTRB, 64'h00); pin(a+1, S_MWEN, 64'd0);
    pin(a+2, S_MVLD, 64'd0); pin(a+3, S_RVLD, 64'd1);
    pin(a+3, S_RDAT, 64'hFFFF_FFFF_8000_0001); pin(a+3, S_RERR, 64'd0);
    t = nxt + 1;
    // Directed: halfword store
    a = t;
    plan_op(a, 64'h8000_0010, 64'h1234, 2'd1, 1'b0, 1'b1, 6'd9, 2, 64'hFFFF, 0, 0, 1, nxt);
    pin(a+1, S_WSTRB, 64'h03); pin(a+1, S_MWEN, 64'd1); pin(a+1, S_MDAT, 64'h1234);
    pin(a+1, S_MADDR, 64'h8000_0010);
    pin(a+5, S_RVLD, 64'd1); pin(a+5, S_RDAT, 64'd0); pin(a+5, S_RERR, 64'd0);
    t = nxt + 1;
    // Directed: flush in IDLE with valid -> not accepted
    stim[t].vld = 1'b1; stim[t].flush = 1'b1;
    pin(t+1, S_RDY, 64'd1); pin(t+1, S_MVLD, 64'd0);
    t = t + 2;
    // Directed: access fault
    a = t;
    plan_op(a, 64'h7000_0000, 64'h0, 2'd2, 1'b0, 1'b0, 6'd1, 0, 64'h0, 0, 0, 0, nxt);
    pin(a+1, S_MVLD, 64'd0); pin(a+1, S_RVLD, 64'd0);
    pin(a+2, S_RVLD, 64'd1); pin(a+2, S_RERR, 64'd1);
    t = nxt + 1;
    // Directed: timeout
    a = t;
    plan_op(a, 64'h9000_0000, 64'h0, 2'd3, 1'b0, 1'b0, 6'd2, TIMEOUT + 50, 64'h0, 0, 0, 0, nxt);
    pin(a+17, S_RVLD, 64'd0); pin(a+18, S_RVLD, 64'd1);
    pin(a+18, S_RERR, 64'd2); pin(a+18, S_RDAT, 64'd0);
    t = nxt + 1;
    // Directed: flush in WAIT, response dropped
    a = t;
    plan_op(a, 64'h8000_0100, 64'h0, 2'd2, 1'b0, 1'b0, 6'd3, 3, 64'h55, 2, 1, 0, nxt);
    pin(a+5, S_RDY, 64'd0); pin(a+6, S_RDY, 64'd1); pin(a+6, S_RVLD, 64'd0);
    t = nxt + 1;
    // Directed: writeback stalls 5 cycles, then reset in RESP
    a = t;
    plan_op(a, 64'h8FFF_FFF8, 64'h0, 2'd3, 1'b1, 1'b0, 6'd4, 4, 64'hDEAD_BEEF_0123_4567, 4, 5, 0, nxt);
    pin(a+7, S_RDAT, 64'hDEAD_BEEF_0123_4567);
    pin(a+12, S_RVLD, 64'd1); pin(a+12, S_RDY, 64'd0);
    pin(a+13, S_RVLD, 64'd0); pin(a+13, S_RDY, 64'd1);
    t = nxt + 2;
    // Directed: response in the timeout cycle wins
    a = t;
    plan_op(a, 64'h9000_0003, 64'h0, 2'd0, 1'b0, 1'b0, 6'd7, TIMEOUT - 1, 64'h80, 0, 0, 0, nxt);
    pin(a+18, S_RERR, 64'd0); pin(a+18, S_RDAT, 64'hFFFF_FFFF_FFFF_FF80);
    t = nxt + 1;
    // Directed: flush in REQ of a store still issues the strobe
    a = t;
    plan_op(a, 64'h8000_0020, 64'hABCD, 2'd2, 1'b0, 1'b1, 6'd8, 1, 64'h0, 1, 0, 0, nxt);
    pin(a+1, S_MVLD, 64'd1); pin(a+1, S_WSTRB, 64'h0F); pin(a+4, S_RVLD, 64'd0);
    t = nxt + 1;
    // Directed: unsigned halfword
    a = t;
    plan_op(a, 64'h9FFF_FFFE, 64'h0, 2'd1, 1'b1, 1'b0, 6'd10, 1, 64'hFFFF_8001, 0, 0, 0, nxt);
    pin(a+4, S_RDAT, 64'h8001);
    t = nxt + 1;

    // Random transactions
    while (t < NCYC - 60) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = {32'h0, ($urandom_range(0, 1) == 1) ? 4'h8 : 4'h9, 28'($urandom)};
      else if (sel == 6) addr = {$urandom, $urandom};
      else if (sel == 7) addr = ($urandom_range(0, 1) == 1) ? 64'h7FFF_FFFF : 64'hA000_0000;
      else if (sel == 8) addr = {32'h0000_0001, 4'h8, 28'($urandom)};
      else               addr = {32'h0, 4'($urandom), 28'($urandom)};
      sel = $urandom_range(0, 9);
      if (sel < 6)       d = $urandom_range(0, 6);
      else if (sel == 6) d = TIMEOUT - 1;
      else if (sel == 7) d = TIMEOUT - 2;
      else if (sel == 8) d = TIMEOUT + 3;
      else               d = $urandom_range(0, TIMEOUT - 1);
      k = $urandom_range(0, 19);
      if (k == 13)                 kind = 1;
      else if (k == 14 || k == 15) kind = 2;
      else if (k == 16 || k == 17) kind = 3;
      else if (k == 18)            kind = 4;
      else                         kind = 0;
      off = (kind == 2) ? $urandom_range(0, 16) : $urandom_range(0, 3);
      r   = $urandom_range(0, 4);
      plan_op(t, addr, {$urandom, $urandom}, 2'($urandom), 1'($urandom), 1'($urandom),
              TAG_W'($urandom), d, {$urandom, $urandom}, kind, off, r, nxt);
      gap = $urandom_range(0, 3);
      for (int c = nxt; c < nxt + gap; c++) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) begin
          stim[c].vld   = 1'b1;
          stim[c].flush = 1'b1;
        end else if (sel == 1) begin
          stim[c].srsp = 1'b1;
        end
      end
      t = nxt + gap;
    end

    // Run: compare outputs at each negedge, then drive the cycle's inputs.
    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      if (c >= 1) begin
        obs.rdy   = lsu_req_ready;
        obs.mvld  = mem_mstReq_valid;
        obs.maddr = mem_addr;
        obs.mdat  = mem_data_w;
        obs.wstrb = mem_wstrb;
        obs.mwen  = mem_wen;
        obs.rvld  = lsu_rsp_valid;
        obs.rdat  = lsu_rsp_data;
        obs.rtag  = lsu_rsp_tag;
        obs.rerr  = lsu_rsp_err;
        tests_run++;
        if (obs !== expv[c]) begin
          fails++;
          $display("FAIL cycle %0d outputs: got rdy=%b req=%b addr=%h wdat=%h strb=%h wen=%b rsp=%b dat=%h tag=%h err=%0d; want rdy=%b req=%b addr=%h wdat=%h strb=%h wen=%b rsp=%b dat=%h tag=%h err=%0d",
                   c, obs.rdy, obs.mvld, obs.maddr, obs.mdat, obs.wstrb, obs.mwen, obs.rvld,
                   obs.rdat, obs.rtag, obs.rerr, expv[c].rdy, expv[c].mvld, expv[c].maddr,
                   expv[c].mdat, expv[c].wstrb, expv[c].mwen, expv[c].rvld, expv[c].rdat,
                   expv[c].rtag, expv[c].rerr);
        end
        foreach (pins[i]) begin
          if (pins[i].cyc == c) begin
            tests_run++;
            if (sig_val(obs, pins[i].sig) !== pins[i].val) begin
              fails++;
              $display("FAIL pin %s at cycle %0d: got %h, want %h", sig_name(pins[i].sig), c,
                       sig_val(obs, pins[i].sig), pins[i].val);
            end
          end
        end
      end
      RST              = stim[c].rst;
      flush            = stim[c].flush;
      lsu_req_valid    = stim[c].vld;
      lsu_addr         = stim[c].addr;
      lsu_data_w       = stim[c].wdat;
      lsu_size         = stim[c].size;
      lsu_unsigned     = stim[c].uns;
      lsu_wen          = stim[c].wen;
      lsu_tag          = stim[c].tag;
      lsu_rsp_ready    = stim[c].rrdy;
      mem_slvRsp_valid = stim[c].srsp;
      mem_data_r       = stim[c].rdat;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
